// File: rtl/layer_seq_ctrl.sv
// Time-multiplexed sequencer for one fully-connected layer: steps a shared MAC/activation
// engine through every neuron's weight/input pairs and publishes all results at once.
module layer_seq_ctrl #(
  parameter int N_IN  = 5,
  parameter int N_OUT = 10,
  parameter int DW    = 8,
  parameter int AW    = 6,
  parameter int LAT   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [N_IN*DW-1:0]    in_vec,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  output logic [N_OUT*DW-1:0]   out_vec,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic [DW-1:0]         mac_x,
  output logic [AW-1:0]         w_addr,
  input  logic [DW-1:0]         mac_result
);

  localparam int KW  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int DCW = (LAT   > 0) ? $clog2(LAT + 1) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [JW-1:0]        j_q, j_d;
  logic [KW-1:0]        k_q, k_d;
  logic [DCW-1:0]       drain_q, drain_d;
  logic                 busy_q;
  logic                 done_q;
  logic                 out_valid_q;
  logic [N_OUT*DW-1:0]  out_vec_q;
  logic [N_IN*DW-1:0]   in_q;
  logic [N_OUT*DW-1:0]  shadow_q;

  logic latch_in;
  logic store_en;
  logic commit;

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    k_d      = k_q;
    drain_d  = drain_q;
    latch_in = 1'b0;
    store_en = 1'b0;
    commit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_MAC;
          j_d      = '0;
          k_d      = '0;
          latch_in = 1'b1;
        end
      end
      S_MAC: begin
        if (k_q == K_LAST) begin
          // A zero-latency engine has its result ready immediately, so skip DRAIN.
          if (LAT == 0) begin
            state_d = S_STORE;
          end else begin
            state_d = S_DRAIN;
            drain_d = DCW'(LAT);
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - DCW'(1);
        if (drain_q == DCW'(1)) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        store_en = 1'b1;
        k_d      = '0;
        if (j_q == J_LAST) begin
          state_d = S_DONE;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort cancels any in-flight work, including the final publish.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      store_en = 1'b0;
      commit   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      j_q         <= '0;
      k_q         <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= commit;
      if (latch_in) begin
        out_valid_q <= 1'b0;
      end else if (commit) begin
        out_valid_q <= 1'b1;
      end
      if (commit) begin
        out_vec_q <= shadow_q;
      end
    end
  end

  // Operand and partial-result storage carries no reset; it is only read after being written.
  always_ff @(posedge clk) begin
    if (latch_in) begin
      in_q <= in_vec;
    end
    if (store_en) begin
      shadow_q[int'(j_q)*DW +: DW] <= mac_result;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;

  assign mac_en  = (state_q == S_MAC);
  assign mac_clr = mac_en && (k_q == '0);
  assign mac_x   = mac_en ? in_q[int'(k_q)*DW +: DW] : '0;
  assign w_addr  = mac_en ? (AW'(j_q) * AW'(N_IN) + AW'(k_q)) : '0;

endmodule

// File: doc/layer_seq_ctrl.md
Name: layer_seq_ctrl

Overview:
- Time-multiplexed sequencer for one fully-connected layer. One shared MAC/activation engine evaluates all N_OUT neurons in turn, instead of N_OUT parallel node instances.
- On start, latches the N_IN input activations. For each neuron it steps the engine through its N_IN weight/input pairs and captures the activated 8-bit result.
- Presents all N_OUT results together as a registered output vector, with a done pulse.
- Sits between the previous layer's output registers and the next layer's inputs. The weight ROM address comes from this block.

Parameters:
- N_IN, 5, inputs per neuron (fan-in).
- N_OUT, 10, neurons in the layer.
- DW, 8, activation data width.
- AW, 6, weight address width; must satisfy 2^AW >= N_IN*N_OUT.
- LAT, 2, cycles from the last mac_en of a neuron until mac_result is valid.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a layer evaluation; accepted only when busy=0.
- abort  in  1  synchronous cancel of a running evaluation.
- in_vec  in  N_IN*DW  input activations; element k is in_vec[k*DW +: DW].
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when out_vec is updated.
- out_valid  out  1  out_vec holds a complete result.
- out_vec  out  N_OUT*DW  results; neuron j is out_vec[j*DW +: DW].
- mac_en  out  1  engine accumulates mac_x * weight[w_addr] this cycle.
- mac_clr  out  1  engine starts a new sum with this term; asserted only together with mac_en.
- mac_x  out  DW  input activation for the current term.
- w_addr  out  AW  weight ROM address = j*N_IN + k.
- mac_result  in  DW  activated neuron output from the engine.

Behaviour:
- Reset (synchronous, active-high) values: every output is 0, including busy, done, out_valid, out_vec, mac_en, mac_clr, mac_x and w_addr. FSM returns to IDLE and counters j and k return to 0. Reset has priority over abort and start.
- FSM states: IDLE, MAC, DRAIN, STORE, DONE.
- IDLE:
  - start=1 → latch in_vec into the internal input register, set j=0 and k=0, clear out_valid, go to MAC. busy is high from the next cycle.
- MAC, one cycle per term:
  - Drive mac_en=1, mac_x = input[k], w_addr = j*N_IN + k.
  - mac_clr=1 only when k=0.
  - If k=N_IN-1, go to DRAIN with a drain counter set to LAT. Otherwise k++.
- DRAIN: hold mac_en=0 and mac_clr=0 for LAT cycles, then go to STORE.
- STORE, one cycle:
  - Write mac_result into shadow slot j and set k=0.
  - If j=N_OUT-1, go to DONE. Otherwise j++ and go to MAC.
- DONE, one cycle:
  - Copy the shadow into out_vec, pulse done=1, set out_valid=1, busy=0, go to IDLE.
- Latency from the start edge to the done pulse: N_OUT*(N_IN+LAT+1)+1 cycles. With defaults this is 81.
- Back-to-back: start may be asserted in the cycle after DONE; it is accepted normally.
- start while busy: ignored, with no effect on counters, in_vec latch or outputs.
- in_vec changes while busy: no effect, because the input register was latched at start.
- abort while busy (any non-IDLE state):
  - Next state is IDLE; busy=0, mac_en=0, no done pulse.
  - out_vec keeps its previous contents; out_valid stays 0 because it was cleared at start.
- abort in IDLE: no effect. If abort and start are both high in IDLE, abort wins and start is not accepted.
- w_addr never exceeds N_IN*N_OUT-1, and j never wraps past N_OUT-1.
- mac_x and w_addr may hold their last values outside MAC; they are meaningful only while mac_en=1.
- out_vec changes only in the DONE cycle or on reset. Partial results are never visible.

Test Plan:
- Basic run (defaults):
  - Bench model computes result = sat8((sum of x*w)>>4) with LAT=2; weights w[a]=a+1, in_vec={5,4,3,2,1} (k=0..4).
  - Required: done pulses exactly 81 cycles after start, and each out_vec[j] equals the model value.
  - Required: the w_addr sequence is 0..49 with no gaps, and mac_clr is high exactly at w_addr 0,5,10,...,45.
- Reset mid-run: assert reset at cycle 30 after start.
  - Required: next cycle all outputs are 0.
  - Required: a new start after reset completes correctly in 81 cycles.
- Abort at cycle 40 after a prior successful run (out_vec=V1).
  - Required: busy=0 the next cycle and no done pulse.
  - Required: out_vec stays V1, and out_valid=0 from the start cycle onward.
- Start while busy: pulse start at cycles 10 and 50, with in_vec changed to all 0xFF at cycle 10.
  - Required: a single done at cycle 81 with results computed from the original in_vec.
- Back-to-back: assert start in the cycle after done, with different in_vec.
  - Required: second done 81 cycles later, out_valid low between the two, out_vec updated atomically both times.
- Parameter corner: N_IN=1, N_OUT=1, LAT=0.
  - Required: done 3 cycles after start, with mac_clr and mac_en both high for one cycle at w_addr 0.
